// File: rtl/imm16_fetch_seq.sv
// Fetches a 16-bit immediate (high byte at the lower address) and loads it via set_high/set_low/value.
// Latency: done four cycles after start with zero-wait memory, plus one cycle per memory wait cycle.
// Backpressure: holds rom_rd/rom_addr until rom_valid; start ignored while busy. Option macro: IMM16_TIMEOUT_EN.
module imm16_fetch_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] pc_in,
    output logic        rom_rd,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_valid,
    output logic        set_high,
    output logic        set_low,
    output logic [7:0]  value,
    output logic        busy,
    output logic        done,
    output logic [15:0] pc_next,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, FETCH_HI, FETCH_LO, FINISH} state_t;

    state_t      state, state_nx;
    logic [15:0] pc, pc_nx;
    logic        rom_rd_nx, set_high_nx, set_low_nx, busy_nx, done_nx;
    logic [15:0] rom_addr_nx, pc_next_nx;
    logic [7:0]  value_nx;
    logic        in_fetch;
    logic        tmo_hit;

    assign in_fetch = (state == FETCH_HI) || (state == FETCH_LO);

`ifdef IMM16_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT = 4'd15;

    logic [3:0] wcnt, wcnt_nx;
    logic       err_nx;

    // Counts consecutive wait cycles; any state change or accepted byte restarts it.
    assign wcnt_nx = (in_fetch && !rom_valid) ? wcnt + 4'd1 : 4'd0;
    assign tmo_hit = in_fetch && !rom_valid && (wcnt == TIMEOUT - 4'd1);
    assign err_nx  = tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= 4'd0;
            err  <= 1'b0;
        end else begin
            wcnt <= wcnt_nx;
            err  <= err_nx;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        rom_rd_nx   = 1'b0;
        rom_addr_nx = rom_addr;
        set_high_nx = 1'b0;
        set_low_nx  = 1'b0;
        value_nx    = value;
        busy_nx     = busy;
        done_nx     = 1'b0;
        pc_next_nx  = pc_next;

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    pc_nx       = pc_in;
                    rom_rd_nx   = 1'b1;
                    rom_addr_nx = pc_in;
                    busy_nx     = 1'b1;
                    state_nx    = FETCH_HI;
                end
            end
            FETCH_HI: begin
                rom_rd_nx = 1'b1;
                if (rom_valid) begin
                    value_nx    = rom_data;
                    set_high_nx = 1'b1;
                    pc_nx       = pc + 16'd1;
                    rom_addr_nx = pc + 16'd1;
                    state_nx    = FETCH_LO;
                end else if (tmo_hit) begin
                    rom_rd_nx = 1'b0;
                    busy_nx   = 1'b0;
                    state_nx  = IDLE;
                end
            end
            FETCH_LO: begin
                rom_rd_nx = 1'b1;
                if (rom_valid) begin
                    value_nx   = rom_data;
                    set_low_nx = 1'b1;
                    rom_rd_nx  = 1'b0;
                    state_nx   = FINISH;
                end else if (tmo_hit) begin
                    rom_rd_nx = 1'b0;
                    busy_nx   = 1'b0;
                    state_nx  = IDLE;
                end
            end
            FINISH: begin
                // pc already points at the low byte, so +1 gives pc_in + 2.
                done_nx    = 1'b1;
                pc_next_nx = pc + 16'd1;
                busy_nx    = 1'b0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= 16'd0;
            rom_rd   <= 1'b0;
            rom_addr <= 16'd0;
            set_high <= 1'b0;
            set_low  <= 1'b0;
            value    <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pc_next  <= 16'd0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            rom_rd   <= rom_rd_nx;
            rom_addr <= rom_addr_nx;
            set_high <= set_high_nx;
            set_low  <= set_low_nx;
            value    <= value_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pc_next  <= pc_next_nx;
        end
    end

endmodule

// File: doc/imm16_fetch_seq.md
# imm16_fetch_seq

Sequencer that fetches a 16-bit immediate operand (LJMP/LCALL target, MOV DPTR,#data16) from code memory and loads it byte-by-byte into the downstream 16-bit register through its set-high / set-low / value port. It sits between the instruction decoder and the DPTR/PC holding register. It reads two consecutive code bytes in 8051 order: high byte at the lower address. It also returns the updated fetch address to the decoder.

## Interface
- TIMEOUT, 15: maximum wait cycles per byte for rom_valid; used only when IMM16_TIMEOUT_EN is defined.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to fetch an immediate; sampled only when busy=0
- pc_in  in  16  address of the high byte; sampled with start
- rom_rd  out  1  code-memory read strobe
- rom_addr  out  16  code-memory byte address
- rom_data  in  8  code-memory read data; valid when rom_valid=1
- rom_valid  in  1  read data valid; may arrive in the same cycle as rom_rd or later
- set_high  out  1  load value into the downstream register's bits [15:8]
- set_low  out  1  load value into the downstream register's bits [7:0]
- value  out  8  byte to load
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse; downstream register holds the full operand
- pc_next  out  16  pc_in + 2, mod 2^16; valid while done=1
- err  out  1  one-cycle timeout pulse; constant 0 when the timeout feature is compiled out

## Operation
- All outputs are registered. Reset values: state IDLE, rom_rd=0, rom_addr=0, set_high=0, set_low=0, value=0, busy=0, done=0, pc_next=0, err=0.
- States: IDLE, FETCH_HI, FETCH_LO, FINISH.
- IDLE: if start=1, latch pc_in into the internal address counter and go to FETCH_HI.
- FETCH_HI: rom_rd=1, rom_addr=pc. On rom_valid=1:
  - register value<=rom_data and set_high<=1 for exactly one cycle
  - increment the address to pc+1, mod 2^16
  - go to FETCH_LO
- FETCH_LO: rom_rd=1, rom_addr=pc+1. On rom_valid=1: register value<=rom_data and set_low<=1 for one cycle, then go to FINISH.
- FINISH: one cycle. Register done<=1 and pc_next<=pc+2, then go to IDLE.
- set_high and set_low are never 1 in the same cycle; the downstream register ignores that combination.
- rom_rd stays high, with a stable rom_addr, until rom_valid is seen. rom_valid outside the fetch states is ignored.
- start while busy=1 is ignored and not queued. start in the cycle done=1 is accepted, because busy=0 then.
- Address wrap: pc_in=0xFFFF fetches 0xFFFF, then 0x0000; pc_next=0x0001.
- Reset mid-operation returns to IDLE with all outputs at reset values. No set pulse is issued in the cycle after reset.

## Timing
- With zero-wait memory (rom_valid=1 in the same cycle as rom_rd), and start sampled at edge 0:
  - cycle 1: FETCH_HI, rom_rd=1
  - cycle 2: set_high=1, FETCH_LO
  - cycle 3: set_low=1, FINISH
  - cycle 4: done=1, busy=0
- Each memory wait cycle adds one cycle to the latency.
- busy=1 from the cycle after start is accepted through the FINISH cycle inclusive.
- The downstream register captures on the edge that ends each set pulse. The full operand is valid there when done=1.

## Configuration
- IMM16_TIMEOUT_EN defined:
  - a 4-bit wait counter clears on entry to each fetch state and increments each cycle rom_valid=0
  - when it reaches TIMEOUT, the block goes to IDLE, pulses err for one cycle, and issues no further set pulses and no done
  - a set_high already issued is not retracted
- IMM16_TIMEOUT_EN not defined:
  - no counter is built; the block waits for rom_valid indefinitely
  - err is tied to 0

## Test plan
- Reset, then idle: every output is 0. start=1, pc_in=0x0100, memory [0x0100]=0x12, [0x0101]=0x34, zero-wait -> set_high with value=0x12 in cycle 2, set_low with value=0x34 in cycle 3, done in cycle 4, pc_next=0x0102, downstream register=0x1234.
- Same fetch with rom_valid delayed 3 cycles per byte -> rom_rd and rom_addr stay stable while waiting; done in cycle 10; operand 0x1234.
- pc_in=0xFFFF, [0xFFFF]=0xAB, [0x0000]=0xCD -> rom_addr sequence 0xFFFF then 0x0000; operand 0xABCD; pc_next=0x0001.
- start pulsed during FETCH_LO, then again in the done cycle -> the first extra start is ignored; the second starts a new sequence with busy=1 in the next cycle.
- rst asserted during the FETCH_LO wait -> next cycle all outputs are 0, no set_low, no done; a fresh start afterwards completes normally.
- IMM16_TIMEOUT_EN defined, rom_valid never asserted -> err pulses once after 15 wait cycles in FETCH_HI; no set pulses, no done; busy=0 afterwards.
